// File: rtl/fp_add_arbiter.sv
// Two-requester arbiter sharing one half-precision adder (IDLE/EXEC/DONE).
// Define FP_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties).
module fp_adder16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);
  logic [15:0] l, s;
  logic [4:0]  el, es, d;
  logic [10:0] ml, ms, msh, norm;
  logic [11:0] acc;
  logic [3:0]  lz;

  always_comb begin
    if (a_i[14:0] >= b_i[14:0]) begin
      l = a_i;
      s = b_i;
    end else begin
      l = b_i;
      s = a_i;
    end
    el   = (l[14:10] == 5'd0) ? 5'd1 : l[14:10];
    es   = (s[14:10] == 5'd0) ? 5'd1 : s[14:10];
    ml   = {|l[14:10], l[9:0]};
    ms   = {|s[14:10], s[9:0]};
    d    = el - es;
    msh  = (d > 5'd11) ? 11'd0 : (ms >> d);
    if (l[15] == s[15])
      acc = {1'b0, ml} + {1'b0, msh};
    else
      acc = {1'b0, ml} - {1'b0, msh};
    lz = 4'd0;
    for (int i = 0; i <= 10; i++)
      if (acc[i]) lz = 4'(10 - i);
    norm  = 11'd0;
    sum_o = 16'h0000;
    if (acc == 12'd0) begin
      sum_o = 16'h0000;
    end else if (acc[11]) begin
      sum_o = {l[15], el + 5'd1, acc[10:1]};
    end else if (el > {1'b0, lz}) begin
      norm  = acc[10:0] << lz;
      sum_o = {l[15], el - {1'b0, lz}, norm[9:0]};
    end else begin
      // result falls into the subnormal range
      norm  = acc[10:0] << (el - 5'd1);
      sum_o = {l[15], 5'd0, norm[9:0]};
    end
  end
endmodule

module fp_add_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp_sum,
  output logic        busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, b_q, sum_q, add_sum;
  logic        gnt_q, ptr_q;
  logic        any_v, pick1, grant;

  assign any_v = req0_valid | req1_valid;

`ifdef FP_ARB_FIXED_PRIO_EN
  assign pick1 = req1_valid & ~req0_valid;
  logic unused_ptr;
  assign unused_ptr = ptr_q;
`else
  // ptr_q holds the last winner; on a tie the other side goes
  assign pick1 = (req0_valid & req1_valid) ? ~ptr_q : req1_valid;
`endif

  assign grant = (state_q == IDLE) & any_v & ~reset;

  fp_adder16 u_add (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (add_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      sum_q   <= 16'h0000;
      gnt_q   <= 1'b0;
      ptr_q   <= RR_INIT;
    end else begin
      state_q <= state_d;
      if (grant) begin
        a_q   <= pick1 ? req1_a : req0_a;
        b_q   <= pick1 ? req1_b : req0_b;
        gnt_q <= pick1;
        ptr_q <= pick1;
      end
      if (state_q == EXEC)
        sum_q <= add_sum;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_v) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = grant & ~pick1;
    req1_ready = grant & pick1;
    rsp0_valid = (state_q == DONE) & ~reset & ~gnt_q;
    rsp1_valid = (state_q == DONE) & ~reset & gnt_q;
    busy       = (state_q != IDLE);
    rsp_sum    = sum_q;
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: vector table, directed corners, random traffic
// with a response scoreboard.
module tb_fp_add_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp_sum;
  logic        busy;
  logic [15:0] exp0, exp1;

  always #5 clk = ~clk;

  fp_add_arbiter #(.RR_INIT(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_sum    (rsp_sum),
    .busy       (busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
  } vec_t;

  typedef struct {
    bit          id;
    logic [15:0] s;
  } sb_t;

  vec_t tbl[8];
  sb_t  sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [15:0] act, input logic [15:0] req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endtask

  task automatic setreq(input bit n, input bit v, input vec_t x);
    if (n) begin
      req1_valid = v; req1_a = x.a; req1_b = x.b; exp1 = x.s;
    end else begin
      req0_valid = v; req0_a = x.a; req0_b = x.b; exp0 = x.s;
    end
  endtask

  function automatic logic rdy(input bit n);
    return n ? req1_ready : req0_ready;
  endfunction

  function automatic logic rsp(input bit n);
    return n ? rsp1_valid : rsp0_valid;
  endfunction

  always @(negedge clk) begin
    sb_t e;
    if (reset !== 1'b0) begin
      sb.delete();
    end else begin
      chk(!(req0_ready && req1_ready), "ready_both",
          16'(req0_ready & req1_ready), 16'h0);
      chk(!((req0_ready || req1_ready) && busy), "ready_busy",
          16'(busy), 16'h0);
      if (req0_valid && req0_ready) sb.push_back('{1'b0, exp0});
      if (req1_valid && req1_ready) sb.push_back('{1'b1, exp1});
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          chk(1'b0, "rsp_unexpected", 16'({rsp1_valid, rsp0_valid}), 16'h0);
        end else begin
          e = sb.pop_front();
          chk(rsp1_valid == e.id && !(rsp0_valid && rsp1_valid), "rsp_id",
              16'({rsp1_valid, rsp0_valid}), e.id ? 16'h2 : 16'h1);
          chk(rsp_sum == e.s, "sb_sum", rsp_sum, e.s);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got %h required %h", 16'h0, 16'h1);
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    setreq(1'b0, 1'b1, tbl[0]);
    setreq(1'b1, 1'b1, tbl[1]);
    @(posedge clk);
    @(negedge clk);
    chk(busy == 1'b0, "rst_busy", 16'(busy), 16'h0);
    chk(rsp_sum == 16'h0, "rst_sum", rsp_sum, 16'h0);
    chk(!req0_ready && !req1_ready, "rst_ready",
        16'({req1_ready, req0_ready}), 16'h0);
    chk(!rsp0_valid && !rsp1_valid, "rst_rsp",
        16'({rsp1_valid, rsp0_valid}), 16'h0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int g[$];
    bit n, h0, h1;
    int k;
    tbl[0] = '{16'h3C00, 16'h4000, 16'h4200};
    tbl[1] = '{16'h3E00, 16'h4100, 16'h4400};
    tbl[2] = '{16'h4200, 16'hBC00, 16'h4000};
    tbl[3] = '{16'hBC00, 16'h3C00, 16'h0000};
    tbl[4] = '{16'h4000, 16'h4000, 16'h4400};
    tbl[5] = '{16'h3C00, 16'h3C00, 16'h4000};
    tbl[6] = '{16'h3800, 16'h3800, 16'h3C00};
    tbl[7] = '{16'hC000, 16'hC000, 16'hC400};
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    exp0 = '0; exp1 = '0;
    do_reset();

    // table: alternate requesters, back-to-back at the 3-cycle rate
    for (int i = 0; i < 8; i++) begin
      n = i[0];
      setreq(n, 1'b1, tbl[i]);
      @(negedge clk);
      chk(rdy(n) == 1'b1, "hs_ready", 16'(rdy(n)), 16'h1);
      chk(rdy(!n) == 1'b0, "hs_other", 16'(rdy(!n)), 16'h0);
      @(posedge clk); #1;
      if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
      @(negedge clk);
      chk(!rsp0_valid && !rsp1_valid, "rsp_early",
          16'({rsp1_valid, rsp0_valid}), 16'h0);
      chk(busy == 1'b1, "busy_exec", 16'(busy), 16'h1);
      @(negedge clk);
      chk(rsp(n) == 1'b1, "rsp_lat", 16'(rsp(n)), 16'h1);
      chk(rsp(!n) == 1'b0, "rsp_other", 16'(rsp(!n)), 16'h0);
      chk(rsp_sum == tbl[i].s, "tbl_sum", rsp_sum, tbl[i].s);
      @(posedge clk); #1;
    end
    repeat (3) @(negedge clk);
    chk(rsp_sum == tbl[7].s, "sum_hold", rsp_sum, tbl[7].s);
    chk(busy == 1'b0, "idle_busy", 16'(busy), 16'h0);

    // both requesters held valid from reset
    do_reset();
    setreq(1'b0, 1'b1, tbl[0]);
    setreq(1'b1, 1'b1, tbl[1]);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_ready) g.push_back(0);
      if (req1_ready) g.push_back(1);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk(g.size() == 4, "arb_count", 16'(g.size()), 16'h4);
    for (int j = 0; j < g.size() && j < 4; j++) begin
`ifdef FP_ARB_FIXED_PRIO_EN
      chk(g[j] == 0, "arb_grant", 16'(g[j]), 16'h0);
`else
      chk(g[j] == ((j % 2 == 0) ? 1 : 0), "arb_grant",
          16'(g[j]), (j % 2 == 0) ? 16'h1 : 16'h0);
`endif
    end

    // operands changed after the handshake must not be used
    setreq(1'b0, 1'b1, tbl[5]);
    @(negedge clk);
    chk(req0_ready == 1'b1, "chg_ready", 16'(req0_ready), 16'h1);
    @(posedge clk); #1;
    req0_a = 16'h4000;
    req0_b = 16'h4000;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk(rsp0_valid == 1'b1, "chg_rsp", 16'(rsp0_valid), 16'h1);
    chk(rsp_sum == 16'h4000, "chg_sum", rsp_sum, 16'h4000);
    @(posedge clk); #1;

    // reset during EXEC aborts the operation
    setreq(1'b1, 1'b1, tbl[1]);
    @(negedge clk);
    chk(req1_ready == 1'b1, "ab_ready", 16'(req1_ready), 16'h1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    setreq(1'b0, 1'b1, tbl[3]);
    @(negedge clk);
    chk(busy == 1'b0, "ab_busy", 16'(busy), 16'h0);
    chk(rsp_sum == 16'h0, "ab_sum", rsp_sum, 16'h0);
    chk(!rsp0_valid && !rsp1_valid, "ab_rsp",
        16'({rsp1_valid, rsp0_valid}), 16'h0);
    chk(req0_ready == 1'b1, "ab_regrant", 16'(req0_ready), 16'h1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk(rsp0_valid == 1'b1, "ab_rsp2", 16'(rsp0_valid), 16'h1);
    chk(rsp_sum == 16'h0000, "ab_sum2", rsp_sum, 16'h0000);
    @(posedge clk); #1;

    // random traffic; valid held until ready
    k = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (h0 || h1) k++;
      @(posedge clk); #1;
      if (!req0_valid || h0)
        setreq(1'b0, 1'($urandom_range(0, 1)), tbl[$urandom_range(0, 7)]);
      if (!req1_valid || h1)
        setreq(1'b1, 1'($urandom_range(0, 1)), tbl[$urandom_range(0, 7)]);
    end
    @(negedge clk);
    h0 = req0_valid && req0_ready;
    h1 = req1_valid && req1_ready;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk(k > 20, "rand_hs", 16'(k), 16'd21);
    chk(sb.size() == 0, "sb_drain", 16'(sb.size()), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
